// File: rtl/sa1_map_pkg.sv
// sa1_map_pkg: shared types and constants for the SA-1 bank mapper.
// Holds the region and staging-FSM enums, the fixed SNES window
// constants and the bank-register reset helper.
package sa1_map_pkg;

  // Decoded region of one SNES address
  typedef enum logic [1:0] {
    REG_NONE  = 2'd0,
    REG_ROM   = 2'd1,
    REG_BWRAM = 2'd2,
    REG_BMAP  = 2'd3
  } region_e;

  // Bank-register staging FSM
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Fixed SNES address windows
  localparam logic [15:0] LOROM_WIN  = 16'h8000;
  localparam logic [15:0] BWRAM_WIN  = 16'h6000;
  localparam logic [7:0]  BWRAM_BANK = 8'h40;
  localparam logic [7:0]  BMAP_BANK  = 8'h60;

  // Bank register i comes out of reset pointing at bank i
  function automatic logic [7:0] bank_reset_value(input int unsigned idx);
    return 8'(idx);
  endfunction

endpackage

// File: rtl/sa1_bank_regs.sv
// sa1_bank_regs: CXB/DXB/EXB/FXB bank registers with shadow staging.
// MMC writes land in the shadow copy and are copied to the live copy
// only between SNES cycles, so an in-flight lookup is never retargeted.
module sa1_bank_regs
  import sa1_map_pkg::*;
#(
  parameter int BANK_W = 3
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   addr_valid,
  input  logic                   cycle_end,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_idx,
  input  logic [BANK_W:0]        cfg_data,
  output logic [3:0][BANK_W-1:0] lookup_bank,
  output logic [3:0]             lookup_en,
  output logic                   cfg_busy
);

  state_e                 state;
  state_e                 state_next;
  logic                   commit_now;
  logic [3:0][BANK_W-1:0] live_bank;
  logic [3:0][BANK_W-1:0] shadow_bank;
  logic [3:0]             live_en;
  logic [3:0]             shadow_en;

  // State register for the staging FSM
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and commit decision; a lookup arriving while a commit is due sees the committed banks
  always_comb begin
    state_next  = state;
    commit_now  = 1'b0;
    lookup_bank = live_bank;
    lookup_en   = live_en;
    case (state)
      ST_IDLE: begin
        if (addr_valid) state_next = ST_ACTIVE;
        else if (cfg_busy) commit_now = 1'b1;
      end
      ST_ACTIVE: begin
        if (addr_valid) commit_now = 1'b1;
        else if (cycle_end) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit_now = 1'b1;
        state_next = addr_valid ? ST_ACTIVE : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (commit_now) begin
      lookup_bank = shadow_bank;
      lookup_en   = shadow_en;
    end
  end

  // Shadow writes, shadow-to-live commit and the busy flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) begin
        live_bank[i]   <= BANK_W'(bank_reset_value(i));
        shadow_bank[i] <= BANK_W'(bank_reset_value(i));
      end
      live_en   <= '0;
      shadow_en <= '0;
      cfg_busy  <= 1'b0;
    end else begin
      if (commit_now) begin
        live_bank <= shadow_bank;
        live_en   <= shadow_en;
      end
      if (cfg_we) begin
        shadow_bank[cfg_idx] <= cfg_data[BANK_W-1:0];
        shadow_en[cfg_idx]   <= cfg_data[BANK_W];
      end
      if (cfg_we)          cfg_busy <= 1'b1;
      else if (commit_now) cfg_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/sa1_bank_mapper.sv
// sa1_bank_mapper: registered SA-1 ROM/BW-RAM address mapper.
// One registered lookup per addr_valid strobe, using the live bank
// registers held in sa1_bank_regs.
// Optional feature macro SA1_BMAP_BITMAP_EN adds the 60-6F bitmap view
// of BW-RAM (ports bmap_en, bmap_4bpp); without it 60-6F is unmapped.
module sa1_bank_mapper
  import sa1_map_pkg::*;
#(
  parameter int                ROM_AW       = 24,
  parameter int                BANK_W       = 3,
  parameter logic [ROM_AW-1:0] SAVERAM_BASE = 'hE00000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [23:0]       SNES_ADDR,
  input  logic              addr_valid,
  input  logic              cycle_end,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_idx,
  input  logic [BANK_W:0]   cfg_data,
  input  logic [ROM_AW-1:0] ROM_MASK,
  input  logic [ROM_AW-1:0] SAVERAM_MASK,
  input  logic [4:0]        bwram_sbm,
`ifdef SA1_BMAP_BITMAP_EN
  input  logic              bmap_en,
  input  logic              bmap_4bpp,
`endif
  output logic [ROM_AW-1:0] ROM_ADDR,
  output logic              IS_ROM,
  output logic              IS_SAVERAM,
  output logic              ROM_HIT,
  output logic              map_valid,
  output logic              cfg_busy,
  output logic [2:0]        bit_sel
);

  // ROM addresses never reach above bit BANK_W+20
  localparam logic [ROM_AW-1:0] ROM_KEEP = ROM_AW'((64'd1 << (BANK_W + 20)) - 64'd1);

  logic [3:0][BANK_W-1:0] lookup_bank;
  logic [3:0]             lookup_en;
  region_e                region;
  logic [1:0]             hi_idx;
  logic [1:0]             lo_idx;
  logic [BANK_W-1:0]      hi_bank;
  logic [BANK_W-1:0]      lo_bank;
  logic [ROM_AW-1:0]      rom_hi;
  logic [ROM_AW-1:0]      rom_lo;
  logic [ROM_AW-1:0]      bw_off;
  logic [ROM_AW-1:0]      next_addr;
  logic [2:0]             next_bsel;
  logic                   next_rom;
  logic                   next_sav;
`ifdef SA1_BMAP_BITMAP_EN
  logic [ROM_AW-1:0]      bmap_off;
`endif

  sa1_bank_regs #(
    .BANK_W(BANK_W)
  ) u_bank_regs (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .addr_valid (addr_valid),
    .cycle_end  (cycle_end),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_data   (cfg_data),
    .lookup_bank(lookup_bank),
    .lookup_en  (lookup_en),
    .cfg_busy   (cfg_busy)
  );

  // Classify the SNES address into ROM, BW-RAM, bitmap or nothing
  always_comb begin
    region = REG_NONE;
    if (SNES_ADDR[23:22] == 2'b11) begin
      region = REG_ROM;
    end else if (!SNES_ADDR[22] && ((SNES_ADDR[15:0] & LOROM_WIN) == LOROM_WIN)) begin
      region = REG_ROM;
    end else if (SNES_ADDR[23:20] == BWRAM_BANK[7:4]) begin
      region = REG_BWRAM;
    end else if (!SNES_ADDR[22] && (SNES_ADDR[15:13] == BWRAM_WIN[15:13])) begin
      region = REG_BWRAM;
    end else if (SNES_ADDR[23:20] == BMAP_BANK[7:4]) begin
`ifdef SA1_BMAP_BITMAP_EN
      region = bmap_en ? REG_BMAP : REG_NONE;
`else
      region = REG_NONE;
`endif
    end
  end

  // Build the candidate ROM and BW-RAM addresses for the current lookup
  always_comb begin
    hi_idx  = SNES_ADDR[21:20];
    lo_idx  = {SNES_ADDR[23], SNES_ADDR[21]};
    hi_bank = lookup_bank[hi_idx];
    lo_bank = lookup_en[lo_idx] ? lookup_bank[lo_idx] : BANK_W'(lo_idx);
    rom_hi  = ROM_AW'({hi_bank, SNES_ADDR[19:0]});
    rom_lo  = ROM_AW'({lo_bank, SNES_ADDR[20:16], SNES_ADDR[14:0]});
    bw_off  = SNES_ADDR[22] ? ROM_AW'(SNES_ADDR[19:0])
                            : ROM_AW'({bwram_sbm, SNES_ADDR[12:0]});
`ifdef SA1_BMAP_BITMAP_EN
    bmap_off = bmap_4bpp ? ROM_AW'(SNES_ADDR[19:1]) : ROM_AW'(SNES_ADDR[19:2]);
`endif
  end

  // Select the mapped address, flags and bitmap sub-byte position
  always_comb begin
    next_addr = '0;
    next_bsel = 3'b000;
    next_rom  = 1'b0;
    next_sav  = 1'b0;
    case (region)
      REG_ROM: begin
        next_rom  = 1'b1;
        next_addr = ((SNES_ADDR[23:22] == 2'b11) ? rom_hi : rom_lo) & ROM_MASK & ROM_KEEP;
      end
      REG_BWRAM: begin
        next_sav  = SAVERAM_MASK[0];
        next_addr = SAVERAM_BASE + (bw_off & SAVERAM_MASK);
      end
`ifdef SA1_BMAP_BITMAP_EN
      REG_BMAP: begin
        next_sav  = 1'b1;
        next_addr = SAVERAM_BASE + (bmap_off & SAVERAM_MASK);
        next_bsel = bmap_4bpp ? {SNES_ADDR[0], 2'b00} : {SNES_ADDR[1:0], 1'b0};
      end
`endif
      default: begin
        next_addr = '0;
      end
    endcase
  end

  // Register the lookup result; results hold until the next strobe
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ROM_ADDR   <= '0;
      IS_ROM     <= 1'b0;
      IS_SAVERAM <= 1'b0;
      bit_sel    <= 3'b000;
      map_valid  <= 1'b0;
    end else begin
      map_valid <= addr_valid;
      if (addr_valid) begin
        ROM_ADDR   <= next_addr;
        IS_ROM     <= next_rom;
        IS_SAVERAM <= next_sav;
        bit_sel    <= next_bsel;
      end
    end
  end

  assign ROM_HIT = IS_ROM | IS_SAVERAM;

endmodule

// File: tb/tb_sa1_bank_mapper.sv
// tb_sa1_bank_mapper: scoreboard bench for sa1_bank_mapper.
// Lookups push their hand-computed result into a queue; a monitor pops
// and compares whenever map_valid is seen. Define SA1_BMAP_BITMAP_EN to
// also cover the bitmap view.
module tb_sa1_bank_mapper;

  typedef struct packed {
    logic [23:0] addr;
    logic        rom;
    logic        sav;
    logic [2:0]  bsel;
  } exp_t;

  logic        CLK;
  logic        RST_N;
  logic [23:0] SNES_ADDR;
  logic        addr_valid;
  logic        cycle_end;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [3:0]  cfg_data;
  logic [23:0] ROM_MASK;
  logic [23:0] SAVERAM_MASK;
  logic [4:0]  bwram_sbm;
`ifdef SA1_BMAP_BITMAP_EN
  logic        bmap_en;
  logic        bmap_4bpp;
`endif
  logic [23:0] ROM_ADDR;
  logic        IS_ROM;
  logic        IS_SAVERAM;
  logic        ROM_HIT;
  logic        map_valid;
  logic        cfg_busy;
  logic [2:0]  bit_sel;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  sa1_bank_mapper dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .SNES_ADDR   (SNES_ADDR),
    .addr_valid  (addr_valid),
    .cycle_end   (cycle_end),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_data    (cfg_data),
    .ROM_MASK    (ROM_MASK),
    .SAVERAM_MASK(SAVERAM_MASK),
    .bwram_sbm   (bwram_sbm),
`ifdef SA1_BMAP_BITMAP_EN
    .bmap_en     (bmap_en),
    .bmap_4bpp   (bmap_4bpp),
`endif
    .ROM_ADDR    (ROM_ADDR),
    .IS_ROM      (IS_ROM),
    .IS_SAVERAM  (IS_SAVERAM),
    .ROM_HIT     (ROM_HIT),
    .map_valid   (map_valid),
    .cfg_busy    (cfg_busy),
    .bit_sel     (bit_sel)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One comparison: count it, report it when it is wrong
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Start a lookup this cycle and record what it must return
  task automatic applyStimulus(input logic [23:0] a, input logic [23:0] ea,
                               input logic er, input logic es, input logic [2:0] eb);
    exp_t e;
    SNES_ADDR  = a;
    addr_valid = 1'b1;
    e.addr = ea;
    e.rom  = er;
    e.sav  = es;
    e.bsel = eb;
    exp_q.push_back(e);
  endtask

  task automatic cfgWrite(input logic [1:0] idx, input logic [3:0] data);
    cfg_we   = 1'b1;
    cfg_idx  = idx;
    cfg_data = data;
  endtask

  // Advance to the next falling edge and drop all strobes
  task automatic step();
    @(negedge CLK);
    addr_valid = 1'b0;
    cycle_end  = 1'b0;
    cfg_we     = 1'b0;
  endtask

  // A complete SNES cycle: lookup, cycle end, commit slot
  task automatic lookupCycle(input logic [23:0] a, input logic [23:0] ea,
                             input logic er, input logic es, input logic [2:0] eb);
    applyStimulus(a, ea, er, es, eb);
    step();
    cycle_end = 1'b1;
    step();
    step();
  endtask

  // Monitor: compare each presented lookup against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (map_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_map_valid: got ROM_ADDR %0h with no lookup pending", ROM_ADDR);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rom_addr", 32'(ROM_ADDR), 32'(e.addr));
          checkOutput("flags_rom_sav_hit_bsel", {26'd0, IS_ROM, IS_SAVERAM, ROM_HIT, bit_sel},
                      {26'd0, e.rom, e.sav, e.rom | e.sav, e.bsel});
        end
      end
    end
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, %0d lookups still pending", exp_q.size());
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus
  initial begin
    RST_N        = 1'b0;
    SNES_ADDR    = '0;
    addr_valid   = 1'b0;
    cycle_end    = 1'b0;
    cfg_we       = 1'b0;
    cfg_idx      = '0;
    cfg_data     = '0;
    ROM_MASK     = 24'hFFFFFF;
    SAVERAM_MASK = 24'h003FFF;
    bwram_sbm    = 5'd1;
`ifdef SA1_BMAP_BITMAP_EN
    bmap_en      = 1'b0;
    bmap_4bpp    = 1'b0;
`endif
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("reset_rom_addr", 32'(ROM_ADDR), 32'h0);
    checkOutput("reset_flags", {28'd0, IS_ROM, IS_SAVERAM, ROM_HIT, map_valid}, 32'h0);
    checkOutput("reset_busy_bitsel", {28'd0, cfg_busy, bit_sel}, 32'h0);
    RST_N = 1'b1;
    step();

    $display("[TB] identity banks after reset");
    lookupCycle(24'hD12345, 24'h112345, 1'b1, 1'b0, 3'd0);
    lookupCycle(24'hC12345, 24'h012345, 1'b1, 1'b0, 3'd0);
    lookupCycle(24'h208000, 24'h100000, 1'b1, 1'b0, 3'd0);
    lookupCycle(24'h808000, 24'h200000, 1'b1, 1'b0, 3'd0);

    $display("[TB] staged write during a cycle");
    applyStimulus(24'hD00010, 24'h100010, 1'b1, 1'b0, 3'd0);
    step();
    cfgWrite(2'd1, 4'b0101);
    step();
    checkOutput("busy_after_write", 32'(cfg_busy), 32'd1);
    checkOutput("issued_addr_held", 32'(ROM_ADDR), 32'h100010);
    cycle_end = 1'b1;
    step();
    checkOutput("busy_in_commit", 32'(cfg_busy), 32'd1);
    step();
    checkOutput("busy_after_commit", 32'(cfg_busy), 32'd0);
    lookupCycle(24'hD00010, 24'h500010, 1'b1, 1'b0, 3'd0);

    $display("[TB] write on the cycle_end edge, lookup in COMMIT");
    applyStimulus(24'hF00000, 24'h300000, 1'b1, 1'b0, 3'd0);
    step();
    cycle_end = 1'b1;
    cfgWrite(2'd3, 4'b0101);
    step();
    checkOutput("busy_same_edge", 32'(cfg_busy), 32'd1);
    applyStimulus(24'hF00000, 24'h500000, 1'b1, 1'b0, 3'd0);
    step();
    checkOutput("busy_after_commit_lookup", 32'(cfg_busy), 32'd0);
    cycle_end = 1'b1;
    step();
    step();

    $display("[TB] back-to-back lookups act as cycle end");
    applyStimulus(24'hF00000, 24'h500000, 1'b1, 1'b0, 3'd0);
    step();
    cfgWrite(2'd3, 4'b0110);
    step();
    applyStimulus(24'hF00000, 24'h600000, 1'b1, 1'b0, 3'd0);
    step();
    cycle_end = 1'b1;
    step();
    step();

    $display("[TB] last write wins, idle commit");
    applyStimulus(24'hD00000, 24'h500000, 1'b1, 1'b0, 3'd0);
    step();
    cfgWrite(2'd1, 4'b0010);
    step();
    cfgWrite(2'd1, 4'b0011);
    step();
    cycle_end = 1'b1;
    step();
    step();
    lookupCycle(24'hD00000, 24'h300000, 1'b1, 1'b0, 3'd0);
    cfgWrite(2'd0, 4'b0111);
    step();
    checkOutput("busy_idle_write", 32'(cfg_busy), 32'd1);
    step();
    checkOutput("busy_idle_commit", 32'(cfg_busy), 32'd0);
    lookupCycle(24'hC00000, 24'h700000, 1'b1, 1'b0, 3'd0);

    $display("[TB] LoROM remap");
    cfgWrite(2'd2, 4'b1110);
    step();
    step();
    lookupCycle(24'h808000, 24'h600000, 1'b1, 1'b0, 3'd0);
    lookupCycle(24'h9FFFFF, 24'h6FFFFF, 1'b1, 1'b0, 3'd0);
    ROM_MASK = 24'h0FFFFF;
    lookupCycle(24'h808000, 24'h000000, 1'b1, 1'b0, 3'd0);
    ROM_MASK = 24'hFFFFFF;

    $display("[TB] BW-RAM and unmapped");
    lookupCycle(24'h006100, 24'hE02100, 1'b0, 1'b1, 3'd0);
    lookupCycle(24'h412345, 24'hE02345, 1'b0, 1'b1, 3'd0);
    lookupCycle(24'h7E0000, 24'h000000, 1'b0, 1'b0, 3'd0);
    lookupCycle(24'h002000, 24'h000000, 1'b0, 1'b0, 3'd0);
`ifdef SA1_BMAP_BITMAP_EN
    lookupCycle(24'h600007, 24'h000000, 1'b0, 1'b0, 3'd0);
    bmap_en = 1'b1;
    lookupCycle(24'h600007, 24'hE00001, 1'b0, 1'b1, 3'd6);
    bmap_4bpp = 1'b1;
    lookupCycle(24'h600007, 24'hE00003, 1'b0, 1'b1, 3'd4);
    bmap_en   = 1'b0;
    bmap_4bpp = 1'b0;
`else
    lookupCycle(24'h600007, 24'h000000, 1'b0, 1'b0, 3'd0);
`endif

    $display("[TB] reset with a staged write pending");
    applyStimulus(24'hD00000, 24'h300000, 1'b1, 1'b0, 3'd0);
    step();
    cfgWrite(2'd1, 4'b0001);
    step();
    checkOutput("busy_before_reset", 32'(cfg_busy), 32'd1);
    RST_N = 1'b0;
    #1;
    checkOutput("midreset_busy_valid", {30'd0, cfg_busy, map_valid}, 32'h0);
    checkOutput("midreset_rom_addr", 32'(ROM_ADDR), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    lookupCycle(24'hD00000, 24'h100000, 1'b1, 1'b0, 3'd0);
    lookupCycle(24'h808000, 24'h200000, 1'b1, 1'b0, 3'd0);
    lookupCycle(24'hC00000, 24'h000000, 1'b1, 1'b0, 3'd0);

    step();
    step();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
